// File: rtl/iq_fifo_dual_pkg.sv
// Shared types and defaults for the dual-issue instruction queue.
// Optional perf counters are enabled by defining IQ_PERF_EN (see iq_fifo_dual.sv).
package iq_fifo_dual_pkg;

    localparam int IQ_DEPTH_DEFAULT = 8;
    localparam int IQ_PAYLOAD_W     = 128;
    localparam int IQ_REG_W         = 5;

    // Per-entry control fields the pairing logic needs to see.
    typedef struct packed {
        logic                is_alu;
        logic                priv;
        logic [IQ_REG_W-1:0] rd;
        logic [IQ_REG_W-1:0] rj;
        logic [IQ_REG_W-1:0] rk;
    } iq_ctrl_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/iq_fifo_dual_if.sv
// Decode->queue enqueue bus and queue->register-read issue bus.
// slave is the queue side, master is the ID/REG side.
interface iq_fifo_dual_if #(
    parameter int PAYLOAD = 128
);
    logic [1:0]         enq_valid;
    logic               enq_ready;
    logic [PAYLOAD-1:0] enq_payload0;
    logic [PAYLOAD-1:0] enq_payload1;
    logic [1:0]         enq_is_alu;
    logic [1:0]         enq_priv;
    logic [4:0]         enq_rd0, enq_rj0, enq_rk0;
    logic [4:0]         enq_rd1, enq_rj1, enq_rk1;

    logic [1:0]         iss_valid;
    logic               iss_ready;
    logic [PAYLOAD-1:0] iss_payload0;
    logic [PAYLOAD-1:0] iss_payload1;
    logic [1:0]         iss_is_alu;
    logic [1:0]         iss_priv;
    logic [4:0]         iss_rd0, iss_rj0, iss_rk0;
    logic [4:0]         iss_rd1, iss_rj1, iss_rk1;

    modport slave (
        input  enq_valid, enq_payload0, enq_payload1, enq_is_alu, enq_priv,
               enq_rd0, enq_rj0, enq_rk0, enq_rd1, enq_rj1, enq_rk1, iss_ready,
        output enq_ready, iss_valid, iss_payload0, iss_payload1, iss_is_alu, iss_priv,
               iss_rd0, iss_rj0, iss_rk0, iss_rd1, iss_rj1, iss_rk1
    );

    modport master (
        output enq_valid, enq_payload0, enq_payload1, enq_is_alu, enq_priv,
               enq_rd0, enq_rj0, enq_rk0, enq_rd1, enq_rj1, enq_rk1, iss_ready,
        input  enq_ready, iss_valid, iss_payload0, iss_payload1, iss_is_alu, iss_priv,
               iss_rd0, iss_rj0, iss_rk0, iss_rd1, iss_rj1, iss_rk1
    );
endinterface

// File: rtl/iq_pair_check.sv
// Decides whether the two oldest queue entries may issue together.
// Register 0 is hardwired zero, so a write to it never creates a hazard.
module iq_pair_check
    import iq_fifo_dual_pkg::*;
(
    input  iq_ctrl_t i_old,
    input  iq_ctrl_t i_young,
    output logic     o_pair_ok
);
    logic w_hazard;

    assign w_hazard = (i_old.rd != '0) &
                      ((i_old.rd == i_young.rj) |
                       (i_old.rd == i_young.rk) |
                       (i_old.rd == i_young.rd));

    assign o_pair_ok = i_old.is_alu & i_young.is_alu &
                       ~i_old.priv & ~i_young.priv & ~w_hazard;
endmodule

// File: rtl/iq_fifo_dual.sv
// Circular dual-issue instruction queue between decode and register read.
// Define IQ_PERF_EN to build the saturating single/dual issue counters.
module iq_fifo_dual
    import iq_fifo_dual_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH_DEFAULT,
    parameter int PAYLOAD = IQ_PAYLOAD_W
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    iq_fifo_dual_if.slave bus,
    output logic [31:0]   perf_dual,
    output logic [31:0]   perf_single
);
    localparam int AW = $clog2(DEPTH);

    logic [PAYLOAD-1:0] r_pl   [DEPTH];
    iq_ctrl_t           r_ctrl [DEPTH];
    logic [AW:0]        r_head, r_tail;

    logic [AW:0]   w_count;
    logic [AW-1:0] w_h0, w_h1, w_t0, w_t1;
    logic          w_enq_fire, w_pair_ok;
    logic [1:0]    w_iss_valid, w_n_enq, w_n_deq;
    iq_ctrl_t      w_enq_c0, w_enq_c1, w_c0, w_c1;

    assign w_count = r_tail - r_head;
    assign w_h0    = r_head[AW-1:0];
    assign w_h1    = w_h0 + AW'(1);
    assign w_t0    = r_tail[AW-1:0];
    assign w_t1    = w_t0 + AW'(1);

    // Credit comes from the registered count only; a same-cycle dequeue does not help.
    assign bus.enq_ready = (w_count <= (AW+1)'(DEPTH - 2));
    assign w_enq_fire    = bus.enq_ready & bus.enq_valid[0] & ~flush;
    assign w_n_enq       = w_enq_fire ? (bus.enq_valid[1] ? 2'd2 : 2'd1) : 2'd0;

    assign w_enq_c0 = '{is_alu: bus.enq_is_alu[0], priv: bus.enq_priv[0],
                        rd: bus.enq_rd0, rj: bus.enq_rj0, rk: bus.enq_rk0};
    assign w_enq_c1 = '{is_alu: bus.enq_is_alu[1], priv: bus.enq_priv[1],
                        rd: bus.enq_rd1, rj: bus.enq_rj1, rk: bus.enq_rk1};

    assign w_c0 = r_ctrl[w_h0];
    assign w_c1 = r_ctrl[w_h1];

    iq_pair_check u_pair_check (
        .i_old     (w_c0),
        .i_young   (w_c1),
        .o_pair_ok (w_pair_ok)
    );

    // Issue is suppressed in a flush cycle so REG never consumes a squashed entry.
    assign w_iss_valid[0] = (w_count != '0) & ~flush;
    assign w_iss_valid[1] = (w_count >= (AW+1)'(2)) & w_pair_ok & ~flush;
    assign w_n_deq        = bus.iss_ready ? popcount2(w_iss_valid) : 2'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + (AW+1)'(w_n_deq);
            r_tail <= r_tail + (AW+1)'(w_n_enq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_pl[w_t0]   <= bus.enq_payload0;
            r_ctrl[w_t0] <= w_enq_c0;
            if (bus.enq_valid[1]) begin
                r_pl[w_t1]   <= bus.enq_payload1;
                r_ctrl[w_t1] <= w_enq_c1;
            end
        end
    end

    // Slot1 fields read as zero unless the second entry is actually co-issued.
    assign bus.iss_valid    = w_iss_valid;
    assign bus.iss_payload0 = r_pl[w_h0];
    assign bus.iss_payload1 = w_iss_valid[1] ? r_pl[w_h1] : '0;
    assign bus.iss_is_alu   = {w_iss_valid[1] & w_c1.is_alu, w_c0.is_alu};
    assign bus.iss_priv     = {w_iss_valid[1] & w_c1.priv, w_c0.priv};
    assign bus.iss_rd0      = w_c0.rd;
    assign bus.iss_rj0      = w_c0.rj;
    assign bus.iss_rk0      = w_c0.rk;
    assign bus.iss_rd1      = w_iss_valid[1] ? w_c1.rd : '0;
    assign bus.iss_rj1      = w_iss_valid[1] ? w_c1.rj : '0;
    assign bus.iss_rk1      = w_iss_valid[1] ? w_c1.rk : '0;

`ifdef IQ_PERF_EN
    logic [31:0] r_perf_dual, r_perf_single;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_dual   <= '0;
            r_perf_single <= '0;
        end else begin
            if ((w_n_deq == 2'd2) && (r_perf_dual != '1))
                r_perf_dual <= r_perf_dual + 32'd1;
            if ((w_n_deq == 2'd1) && (r_perf_single != '1))
                r_perf_single <= r_perf_single + 32'd1;
        end
    end

    assign perf_dual   = r_perf_dual;
    assign perf_single = r_perf_single;
`else
    assign perf_dual   = '0;
    assign perf_single = '0;
`endif

endmodule

// File: tb/tb_iq_fifo_dual.sv
// Directed bench for iq_fifo_dual: pairing rules, full/almost-full credit,
// wrap-around pairing, privileged serialisation, flush priority and perf counters.
module tb_iq_fifo_dual;
    logic        clk;
    logic        rstn;
    logic        flush;
    logic [31:0] perf_dual;
    logic [31:0] perf_single;

    int n_chk = 0;
    int n_err = 0;

`ifdef IQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    iq_fifo_dual_if #(.PAYLOAD(128)) bus ();

    iq_fifo_dual u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .bus         (bus),
        .perf_dual   (perf_dual),
        .perf_single (perf_single)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int s, input logic alu, input logic pv,
                            input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk,
                            input logic [127:0] pl);
        if (s == 0) begin
            bus.enq_is_alu[0] = alu; bus.enq_priv[0] = pv;
            bus.enq_rd0 = rd; bus.enq_rj0 = rj; bus.enq_rk0 = rk;
            bus.enq_payload0 = pl;
        end else begin
            bus.enq_is_alu[1] = alu; bus.enq_priv[1] = pv;
            bus.enq_rd1 = rd; bus.enq_rj1 = rj; bus.enq_rk1 = rk;
            bus.enq_payload1 = pl;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [127:0] perf_exp(input int n);
        return PERF ? 128'(n) : 128'(0);
    endfunction

    logic [127:0] held_pl;

    initial begin
        rstn = 1'b0; flush = 1'b0;
        bus.enq_valid = 2'b00; bus.iss_ready = 1'b0;
        set_slot(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 128'h0);
        set_slot(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 128'h0);
        repeat (2) cyc();
        chk("rst_iss_valid", 128'(bus.iss_valid), 128'(2'b00));
        chk("rst_enq_ready", 128'(bus.enq_ready), 128'(1'b1));
        chk("rst_count", 128'(u_dut.w_count), 128'(0));
        chk("rst_perf_dual", 128'(perf_dual), 128'(0));
        rstn = 1'b1;
        cyc();

        // 1: independent ALU pair dual-issues the cycle after enqueue
        set_slot(0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 128'hA0);
        set_slot(1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 128'hB0);
        bus.enq_valid = 2'b11; bus.iss_ready = 1'b1;
        cyc();
        bus.enq_valid = 2'b00;
        chk("t1_iss_valid", 128'(bus.iss_valid), 128'(2'b11));
        chk("t1_payload0", bus.iss_payload0, 128'hA0);
        chk("t1_payload1", bus.iss_payload1, 128'hB0);
        chk("t1_rd0", 128'(bus.iss_rd0), 128'(1));
        chk("t1_rd1", 128'(bus.iss_rd1), 128'(3));
        chk("t1_rj1", 128'(bus.iss_rj1), 128'(4));
        cyc();
        chk("t1_count_after", 128'(u_dut.w_count), 128'(0));
        chk("t1_iss_empty", 128'(bus.iss_valid), 128'(2'b00));
        chk("t1_perf_dual", 128'(perf_dual), perf_exp(1));

        // 2: RAW hazard rd0=5 -> rj1=5 serialises
        set_slot(0, 1'b1, 1'b0, 5'd5, 5'd1, 5'd0, 128'hC0);
        set_slot(1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 128'hD0);
        bus.enq_valid = 2'b11;
        cyc();
        bus.enq_valid = 2'b00;
        chk("t2_first_valid", 128'(bus.iss_valid), 128'(2'b01));
        chk("t2_first_pl", bus.iss_payload0, 128'hC0);
        chk("t2_pl1_zero", bus.iss_payload1, 128'h0);
        cyc();
        chk("t2_second_valid", 128'(bus.iss_valid), 128'(2'b01));
        chk("t2_second_pl", bus.iss_payload0, 128'hD0);
        cyc();
        chk("t2_empty", 128'(bus.iss_valid), 128'(2'b00));
        chk("t2_perf_single", 128'(perf_single), perf_exp(2));

        // 3: writes to x0 never block pairing
        set_slot(0, 1'b1, 1'b0, 5'd0, 5'd3, 5'd4, 128'hE0);
        set_slot(1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 128'hF0);
        bus.enq_valid = 2'b11;
        cyc();
        bus.enq_valid = 2'b00;
        chk("t3_x0_dual", 128'(bus.iss_valid), 128'(2'b11));
        cyc();

        // 4a: fill all 8 entries while REG is stalled, then drain
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_slot(0, 1'b1, 1'b0, 5'(10 + 2*k), 5'd0, 5'd0, 128'(8'h40 + 2*k));
            set_slot(1, 1'b1, 1'b0, 5'(11 + 2*k), 5'd0, 5'd0, 128'(8'h41 + 2*k));
            chk("t4_ready_filling", 128'(bus.enq_ready), 128'(1'b1));
            bus.enq_valid = 2'b11;
            cyc();
        end
        bus.enq_valid = 2'b00;
        chk("t4_count8", 128'(u_dut.w_count), 128'(8));
        chk("t4_ready_full", 128'(bus.enq_ready), 128'(1'b0));
        chk("t4_held_valid", 128'(bus.iss_valid), 128'(2'b11));
        held_pl = bus.iss_payload0;
        chk("t4_head_pl", held_pl, 128'h40);
        set_slot(0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 128'hEE);
        set_slot(1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 128'hEF);
        bus.enq_valid = 2'b11;
        cyc();
        bus.enq_valid = 2'b00;
        chk("t4_full_drop", 128'(u_dut.w_count), 128'(8));
        chk("t4_stable_pl0", bus.iss_payload0, 128'h40);
        chk("t4_stable_pl1", bus.iss_payload1, 128'h41);
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_drain_valid", 128'(bus.iss_valid), 128'(2'b11));
            chk("t4_drain_pl0", bus.iss_payload0, 128'(8'h40 + 2*k));
            cyc();
        end
        chk("t4_drained", 128'(u_dut.w_count), 128'(0));

        // 4b: count 7 also withholds credit; odd count leaves a single at the end
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_slot(0, 1'b1, 1'b0, 5'(20 + 2*k), 5'd0, 5'd0, 128'(8'h50 + 2*k));
            set_slot(1, 1'b1, 1'b0, 5'(21 + 2*k), 5'd0, 5'd0, 128'(8'h51 + 2*k));
            bus.enq_valid = 2'b11;
            cyc();
        end
        set_slot(0, 1'b1, 1'b0, 5'd26, 5'd0, 5'd0, 128'h56);
        bus.enq_valid = 2'b01;
        cyc();
        chk("t4_count7", 128'(u_dut.w_count), 128'(7));
        chk("t4_ready_at7", 128'(bus.enq_ready), 128'(1'b0));
        bus.enq_valid = 2'b11;
        cyc();
        bus.enq_valid = 2'b00;
        chk("t4_drop_at7", 128'(u_dut.w_count), 128'(7));
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t4b_valid", 128'(bus.iss_valid), 128'(2'b11));
            chk("t4b_pl1", bus.iss_payload1, 128'(8'h51 + 2*k));
            cyc();
        end
        chk("t4b_single", 128'(bus.iss_valid), 128'(2'b01));
        chk("t4b_single_pl", bus.iss_payload0, 128'h56);
        cyc();
        chk("t4b_empty", 128'(u_dut.w_count), 128'(0));

        // 5: priv at h+1 is held back, issues alone, then an ALU pair across the wrap
        set_slot(0, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 128'h60);
        set_slot(1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 128'h61);
        bus.enq_valid = 2'b11;
        cyc();
        set_slot(0, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 128'h62);
        set_slot(1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 128'h63);
        chk("t5_alu_alone", 128'(bus.iss_valid), 128'(2'b01));
        chk("t5_alu_pl", bus.iss_payload0, 128'h60);
        cyc();
        bus.enq_valid = 2'b00;
        chk("t5_priv_alone", 128'(bus.iss_valid), 128'(2'b01));
        chk("t5_priv_pl", bus.iss_payload0, 128'h61);
        chk("t5_priv_flag", 128'(bus.iss_priv), 128'(2'b01));
        cyc();
        chk("t5_wrap_pair", 128'(bus.iss_valid), 128'(2'b11));
        chk("t5_wrap_pl0", bus.iss_payload0, 128'h62);
        chk("t5_wrap_pl1", bus.iss_payload1, 128'h63);
        cyc();
        chk("t5_empty", 128'(u_dut.w_count), 128'(0));
        chk("t5_perf_dual", 128'(perf_dual), perf_exp(10));
        chk("t5_perf_single", 128'(perf_single), perf_exp(5));

        // 6: flush at count 5 beats concurrent enqueue and issue
        bus.iss_ready = 1'b0;
        set_slot(0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 128'h70);
        set_slot(1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 128'h71);
        bus.enq_valid = 2'b11;
        cyc();
        cyc();
        set_slot(0, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 128'h74);
        bus.enq_valid = 2'b01;
        cyc();
        chk("t6_count5", 128'(u_dut.w_count), 128'(5));
        set_slot(0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 128'h80);
        set_slot(1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 128'h81);
        bus.enq_valid = 2'b11; bus.iss_ready = 1'b1; flush = 1'b1;
        #1;
        chk("t6_flush_no_issue", 128'(bus.iss_valid), 128'(2'b00));
        cyc();
        flush = 1'b0; bus.enq_valid = 2'b00;
        chk("t6_count0", 128'(u_dut.w_count), 128'(0));
        chk("t6_iss_valid0", 128'(bus.iss_valid), 128'(2'b00));
        chk("t6_enq_ready", 128'(bus.enq_ready), 128'(1'b1));
        chk("t6_perf_kept", 128'(perf_dual), perf_exp(10));
        set_slot(0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 128'h90);
        set_slot(1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 128'h91);
        bus.enq_valid = 2'b11;
        cyc();
        bus.enq_valid = 2'b00;
        chk("t6_post_valid", 128'(bus.iss_valid), 128'(2'b11));
        chk("t6_post_pl0", bus.iss_payload0, 128'h90);
        cyc();
        chk("t6_post_perf", 128'(perf_dual), perf_exp(11));

        rstn = 1'b0;
        #1;
        chk("final_rst_perf_dual", 128'(perf_dual), 128'(0));
        chk("final_rst_perf_single", 128'(perf_single), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
